// File: rtl/aes_pkg.sv
// Shared AES types, constants and helpers for the key schedule datapath.
// A round key is four 32-bit words with k0 in the most significant position.
package aes_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NR      = 10;
  localparam logic [BYTE_W-1:0] RCON_INIT = 8'h01;

  typedef logic [WORD_W-1:0] word32;

  typedef struct packed {
    word32 k0;
    word32 k1;
    word32 k2;
    word32 k3;
  } block128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_MIX
  } ks_state_e;

  // GF(2^8) multiply-by-x with the AES reduction polynomial.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/S4.sv
// Four parallel AES S-boxes (SubWord) with a single output register stage.
// Output is valid one cycle after the input word is presented.
module S4 (
  input  logic        clk,
  input  logic [31:0] in,
  output logic [31:0] out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  always_ff @(posedge clk) begin
    out <= {SBOX[in[31:24]], SBOX[in[23:16]], SBOX[in[15:8]], SBOX[in[7:0]]};
  end

endmodule

// File: rtl/aes_key_sched_128.sv
// Iterative AES-128 key expander: emits round keys 1..10, one every two cycles.
// SubWord goes through the registered S4 in SUB; the XOR chain completes in MIX.
module aes_key_sched_128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic [127:0] round_key,
  output logic         done
);

  localparam int unsigned IDX_W = 4;

  ks_state_e            state, state_d;
  block128              cur_key, cur_key_d, new_key;
  logic [BYTE_W-1:0]    rcon, rcon_d;
  logic [IDX_W-1:0]     rnd, rnd_d, round_idx_d;
  logic [127:0]         round_key_d;
  logic                 busy_d, key_valid_d, done_d;
  word32                sub_in, sub_out, t, w0, w1, w2, w3;

  assign sub_in = {cur_key.k3[23:0], cur_key.k3[31:24]};

  S4 u_s4 (
    .clk (clk),
    .in  (sub_in),
    .out (sub_out)
  );

  // Next round key: each word folds in the freshly computed word before it.
  assign t  = sub_out ^ {rcon, 24'h0};
  assign w0 = cur_key.k0 ^ t;
  assign w1 = cur_key.k1 ^ w0;
  assign w2 = cur_key.k2 ^ w1;
  assign w3 = cur_key.k3 ^ w2;
  assign new_key = '{k0: w0, k1: w1, k2: w2, k3: w3};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    cur_key_d   = cur_key;
    rcon_d      = rcon;
    rnd_d       = rnd;
    round_key_d = round_key;
    round_idx_d = round_idx;
    key_valid_d = 1'b0;
    done_d      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SUB;
          cur_key_d = key_in;
          rcon_d    = RCON_INIT;
          rnd_d     = IDX_W'(1);
        end
      end
      ST_SUB: state_d = ST_MIX;
      ST_MIX: begin
        cur_key_d   = new_key;
        round_key_d = new_key;
        round_idx_d = rnd;
        key_valid_d = 1'b1;
        done_d      = (rnd == IDX_W'(NR));
        rnd_d       = rnd + IDX_W'(1);
        rcon_d      = xtime(rcon);
        state_d     = (rnd < IDX_W'(NR)) ? ST_SUB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_key   <= '0;
      rcon      <= RCON_INIT;
      rnd       <= '0;
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur_key   <= cur_key_d;
      rcon      <= rcon_d;
      rnd       <= rnd_d;
      round_key <= round_key_d;
      round_idx <= round_idx_d;
      key_valid <= key_valid_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_128.sv
// Directed and random-key bench for aes_key_sched_128 against an independent
// key-expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_sched_128;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic [3:0]   round_idx;
  logic [127:0] round_key;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0]   sb [256];
  logic [127:0] exp_key [1:10];
  logic [127:0] got_key [1:10];
  int           got_cyc [1:10];
  int           n_valid, done_cnt, done_cyc, busy_drop;
  logic         busy_end;

  aes_key_sched_128 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .key_valid (key_valid),
    .round_idx (round_idx),
    .round_key (round_key),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] a = a_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, tw;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tw = {w3[23:0], w3[31:24]};
      tw = {sb[tw[31:24]], sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ tw;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      exp_key[r] = {w0, w1, w2, w3};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endtask

  // Pulse start with key, then observe the 20 cycles up to and including the done cycle.
  task automatic run(input logic [127:0] key, input int restart_at, input logic [127:0] alt);
    n_valid = 0; done_cnt = 0; done_cyc = -1; busy_drop = 0;
    for (int n = 1; n <= 10; n++) begin
      got_key[n] = 'x;
      got_cyc[n] = -1;
    end
    key_in = key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    key_in = ~key;
    for (int c = 1; c <= 20; c++) begin
      if (c == restart_at) begin
        start  = 1'b1;
        key_in = alt;
      end
      tick();
      start = 1'b0;
      if (key_valid) begin
        n_valid++;
        if (n_valid <= 10) begin
          got_key[n_valid] = round_key;
          got_cyc[n_valid] = c;
        end
        check_eq($sformatf("round_idx@%0d", c), 128'(round_idx), 128'(n_valid));
      end
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c < 20 && !busy) busy_drop++;
    end
    busy_end = busy;
  endtask

  task automatic verify(input string t);
    check_eq({t, " n_valid"}, 128'(n_valid), 128'd10);
    for (int n = 1; n <= 10; n++) begin
      check_eq($sformatf("%s rk%0d", t, n), got_key[n], exp_key[n]);
      check_eq($sformatf("%s cyc%0d", t, n), 128'(got_cyc[n]), 128'(2 * n));
    end
    check_eq({t, " done_cnt"}, 128'(done_cnt), 128'd1);
    check_eq({t, " done_cyc"}, 128'(done_cyc), 128'd20);
    check_eq({t, " busy_drop"}, 128'(busy_drop), 128'd0);
    check_eq({t, " busy_end"}, 128'(busy_end), 128'd0);
  endtask

  task automatic idle_check(input string t, input int cycles);
    int hits = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (key_valid || busy || done) hits++;
    end
    check_eq({t, " idle"}, 128'(hits), 128'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; key_in = '0;
    build_sbox();
    tick(); tick(); tick();
    reset = 1'b0;

    check_eq("rst busy", 128'(busy), 128'd0);
    check_eq("rst key_valid", 128'(key_valid), 128'd0);
    check_eq("rst done", 128'(done), 128'd0);
    check_eq("rst round_idx", 128'(round_idx), 128'd0);
    check_eq("rst round_key", round_key, 128'd0);

    // FIPS-197 key, then the zero key started in the done cycle
    model_expand(KEY_A);
    run(KEY_A, -1, '0);
    verify("t1");
    check_eq("t1 rk1 const", got_key[1], A_RK1);
    check_eq("t1 rk10 const", got_key[10], A_RK10);

    model_expand('0);
    run('0, -1, '0);
    verify("t5");
    check_eq("t5 rk1 const", got_key[1], Z_RK1);
    check_eq("t5 rk10 const", got_key[10], Z_RK10);
    idle_check("t2", 4);

    // start re-pulsed mid-expansion with a different key
    model_expand(KEY_A);
    run(KEY_A, 5, KEY_B);
    verify("t3");
    idle_check("t3", 2);

    // reset at E0+9 together with a start: reset must win
    key_in = KEY_A;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    reset = 1'b1;
    start = 1'b1;
    key_in = KEY_B;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check_eq("t4 busy", 128'(busy), 128'd0);
    check_eq("t4 key_valid", 128'(key_valid), 128'd0);
    check_eq("t4 done", 128'(done), 128'd0);
    check_eq("t4 round_idx", 128'(round_idx), 128'd0);
    check_eq("t4 round_key", round_key, 128'd0);
    model_expand(KEY_A);
    run(KEY_A, -1, '0);
    verify("t4");
    idle_check("t4", 2);

    // random keys against the software model
    for (int k = 0; k < 200; k++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rk);
      run(rk, -1, '0);
      verify($sformatf("t6.%0d", k));
      idle_check($sformatf("t6.%0d", k), 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
